// File: rtl/soft_oser8_pkg.sv
// Shared definitions for the soft 8:1 output serializer: frame geometry and
// the shifter state that marks whether the frame on the wire carries user data.
package soft_oser8_pkg;

    localparam int FRAME_W = 8;
    localparam int CNT_W   = $clog2(FRAME_W);

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } shift_state_e;

endpackage

// File: rtl/soft_oser8.sv
// Soft 8:1 serializer: one bit per clk, frames always 8-bit aligned, with a
// single holding register that feeds the shifter at every frame boundary.
module soft_oser8
    import soft_oser8_pkg::*;
#(
    parameter logic [FRAME_W-1:0] IDLE_PATTERN = 8'h00,
    parameter bit                 MSB_FIRST    = 1'b0
) (
    input  logic               clk,
    input  logic               srst,
    input  logic [FRAME_W-1:0] din,
    input  logic               din_vld,
    output logic               din_rdy,
    output logic               q,
    output logic               q_frame,
    output logic               q_data,
    output logic               underrun
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    shift_state_e       state_q, state_d;
    logic               q_q, q_d;
    logic               q_frame_q, q_frame_d;
    logic               q_data_q, q_data_d;
    logic               underrun_q, underrun_d;
    logic [CNT_W-1:0]   bit_sel;
    logic               accept;

    // Handshake: a byte transfers on a clk edge where din_vld && din_rdy;
    // din_rdy depends only on the holding register, never on din_vld.
    assign din_rdy = !hold_full_q;
    assign accept  = din_vld && !hold_full_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q       <= '0;
            shreg_q     <= IDLE_PATTERN;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            state_q     <= IDLE;
            q_q         <= 1'b0;
            q_frame_q   <= 1'b0;
            q_data_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            state_q     <= state_d;
            q_q         <= q_d;
            q_frame_q   <= q_frame_d;
            q_data_q    <= q_data_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        state_d     = state_q;
        underrun_d  = 1'b0;
        bit_sel     = MSB_FIRST ? (LAST_CNT - cnt_q) : cnt_q;
        q_d         = shreg_q[bit_sel];
        q_frame_d   = (cnt_q == '0);
        q_data_d    = (state_q == DATA);

        // Frame boundary: the holding register is emptied here, so an accept on
        // this same edge can only happen when it was already empty.
        if (cnt_q == LAST_CNT) begin
            if (hold_full_q) begin
                shreg_d     = hold_q;
                state_d     = DATA;
                hold_full_d = 1'b0;
            end else begin
                shreg_d    = IDLE_PATTERN;
                state_d    = IDLE;
                underrun_d = (state_q == DATA);
            end
        end

        if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end
    end

    assign q        = q_q;
    assign q_frame  = q_frame_q;
    assign q_data   = q_data_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_soft_oser8.sv
// Bench for soft_oser8: two instances (LSB-first with idle 8'hA5, MSB-first
// with idle 8'h00) checked every cycle against a frame-timeline model.
module tb_soft_oser8;

    logic       clk = 1'b0;
    logic       srst;
    logic [7:0] din0, din1;
    logic [1:0] vld, rdy, q, qf, qd, ur;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    soft_oser8 #(.IDLE_PATTERN(8'hA5), .MSB_FIRST(1'b0)) u0 (
        .clk(clk), .srst(srst), .din(din0), .din_vld(vld[0]), .din_rdy(rdy[0]),
        .q(q[0]), .q_frame(qf[0]), .q_data(qd[0]), .underrun(ur[0])
    );

    soft_oser8 #(.IDLE_PATTERN(8'h00), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .srst(srst), .din(din1), .din_vld(vld[1]), .din_rdy(rdy[1]),
        .q(q[1]), .q_frame(qf[1]), .q_data(qd[1]), .underrun(ur[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: timeline of frames since reset. Frame f occupies output cycles
    // 8f+1 .. 8f+8; its content is fixed at the last cycle of frame f-1.
    logic [7:0] m_idle [2] = '{8'hA5, 8'h00};
    bit         m_msb  [2] = '{1'b0, 1'b1};
    logic [7:0] fr_byte [2][256];
    bit         fr_data [2][256];
    logic [7:0] m_hold [2];
    bit         m_full [2];
    int         m_k    [2];
    logic [1:0] e_q, e_f, e_d, e_u, e_r;
    int         f, nf, pos;
    logic [7:0] cur;
    bit         accept;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (srst) begin
                m_k[i]        = 0;
                m_full[i]     = 1'b0;
                fr_byte[i][0] = m_idle[i];
                fr_data[i][0] = 1'b0;
                e_q[i] = 1'b0; e_f[i] = 1'b0; e_d[i] = 1'b0; e_u[i] = 1'b0;
            end else begin
                f      = (m_k[i] / 8) % 256;
                pos    = m_k[i] % 8;
                accept = vld[i] && !m_full[i];
                cur    = fr_byte[i][f];
                e_q[i] = m_msb[i] ? cur[7 - pos] : cur[pos];
                e_f[i] = (pos == 0);
                e_d[i] = fr_data[i][f];
                e_u[i] = 1'b0;
                if (pos == 7) begin
                    nf = (f + 1) % 256;
                    fr_byte[i][nf] = m_full[i] ? m_hold[i] : m_idle[i];
                    fr_data[i][nf] = m_full[i];
                    m_full[i] = 1'b0;
                    e_u[i] = fr_data[i][f] && !fr_data[i][nf];
                end
                if (accept) begin
                    m_hold[i] = (i == 0) ? din0 : din1;
                    m_full[i] = 1'b1;
                end
                m_k[i]++;
            end
            e_r[i] = !m_full[i];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q", {30'd0, q}, {30'd0, e_q});
            chk("q_frame", {30'd0, qf}, {30'd0, e_f});
            chk("q_data", {30'd0, qd}, {30'd0, e_d});
            chk("underrun", {30'd0, ur}, {30'd0, e_u});
            chk("din_rdy", {30'd0, rdy}, {30'd0, e_r});
        end
    end

    // Capture of instance 0 outputs for window-based checks.
    bit mon_on = 1'b0;
    bit mq_q[$], mq_d[$], mq_u[$];

    always @(negedge clk) begin
        if (mon_on) begin
            mq_q.push_back(q[0]);
            mq_d.push_back(qd[0]);
            mq_u.push_back(ur[0]);
        end
    end

    task automatic send(input int i, input logic [7:0] b);
        int t = 0;
        if (i == 0) din0 = b; else din1 = b;
        vld[i] = 1'b1;
        while (!rdy[i] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("send_rdy", {31'd0, rdy[i]}, 32'd1);
        @(negedge clk);
    endtask

    task automatic align(input int c);
        int t = 0;
        while ((m_k[0] % 8) != c && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("align", m_k[0] % 8, c);
    endtask

    task automatic wait_data(input int i, output int lat);
        lat = 0;
        while (!qd[i] && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_q"}, {30'd0, q}, 32'd0);
        chk({tag, "_q_frame"}, {30'd0, qf}, 32'd0);
        chk({tag, "_q_data"}, {30'd0, qd}, 32'd0);
        chk({tag, "_underrun"}, {30'd0, ur}, 32'd0);
        chk({tag, "_din_rdy"}, {30'd0, rdy}, 32'd3);
    endtask

    task automatic check_idle_16(input string tag);
        logic [15:0] cq, cf;
        bit any_d, any_u;
        cq = '0; cf = '0; any_d = 1'b0; any_u = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            cq[c] = q[0];
            cf[c] = qf[0];
            any_d |= qd[0];
            any_u |= ur[0];
        end
        chk({tag, "_q_bits"}, {16'd0, cq}, 32'h0000A5A5);
        chk({tag, "_q_frame_bits"}, {16'd0, cf}, 32'h00000101);
        chk({tag, "_q_data_any"}, {31'd0, any_d}, 32'd0);
        chk({tag, "_underrun_any"}, {31'd0, any_u}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rdyl, first, nd, nu;
        logic [7:0]  b8, d8, u8;
        logic [31:0] qv, dv, uv;

        srst = 1'b1; vld = 2'b00; din0 = 8'h00; din1 = 8'h00;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_reset_outputs("reset");
        srst = 1'b0;

        // Idle stream after reset: A5 LSB-first, frame marker every 8 cycles.
        check_idle_16("idle");

        // Byte accepted at the cnt==2 edge goes out in the next frame.
        align(2);
        send(0, 8'h3C);
        vld[0] = 1'b0;
        wait_data(0, lat);
        chk("lat_cnt2", lat, 6);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            b8[c] = q[0]; d8[c] = qd[0]; u8[c] = ur[0];
        end
        chk("byte3c_bits", {24'd0, b8}, 32'h3C);
        chk("byte3c_q_data", {24'd0, d8}, 32'hFF);
        chk("byte3c_underrun", {24'd0, u8}, 32'h80);
        @(negedge clk);
        chk("underrun_one_cycle", {31'd0, ur[0]}, 32'd0);

        // Back-to-back stream with din_vld held high.
        repeat (5) @(negedge clk);
        mq_q.delete(); mq_d.delete(); mq_u.delete();
        mon_on = 1'b1;
        send(0, 8'h01);
        send(0, 8'h80);
        send(0, 8'hFF);
        vld[0] = 1'b0;
        repeat (40) @(negedge clk);
        mon_on = 1'b0;
        first = -1; nd = 0; nu = 0;
        for (int x = 0; x < mq_d.size(); x++) begin
            if (first < 0 && mq_d[x]) first = x;
            nd += int'(mq_d[x]);
            nu += int'(mq_u[x]);
        end
        qv = '0; dv = '0; uv = '0;
        if (first >= 0 && first + 32 <= mq_d.size()) begin
            for (int x = 0; x < 32; x++) begin
                qv[x] = mq_q[first + x];
                dv[x] = mq_d[first + x];
                uv[x] = mq_u[first + x];
            end
        end
        chk("stream_q_bits", qv, 32'hA5FF8001);
        chk("stream_q_data", dv, 32'h00FFFFFF);
        chk("stream_underrun", uv, 32'h00800000);
        chk("stream_data_count", nd, 24);
        chk("stream_underrun_count", nu, 1);

        // Byte accepted at the cnt==7 edge waits a whole idle frame.
        align(7);
        send(0, 8'h5A);
        vld[0] = 1'b0;
        lat = 0; rdyl = 0;
        while (!qd[0] && lat < 30) begin
            if (!rdy[0]) rdyl++;
            @(negedge clk);
            lat++;
        end
        chk("lat_cnt7", lat, 9);
        chk("rdy_low_cycles", rdyl, 8);

        // MSB-first instance, recovered with a q[0]-first deserializer.
        repeat (12) @(negedge clk);
        send(1, 8'h81);
        vld[1] = 1'b0;
        wait_data(1, lat);
        chk("msb_frame_start", {31'd0, qf[1]}, 32'd1);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            b8[c] = q[1];
        end
        chk("msb_recover_81", {24'd0, b8}, 32'h81);
        send(1, 8'h12);
        vld[1] = 1'b0;
        wait_data(1, lat);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            b8[c] = q[1];
        end
        chk("msb_order_12", {24'd0, b8}, 32'h48);

        // Reset in the middle of a data frame with a second byte held.
        repeat (4) @(negedge clk);
        send(0, 8'hC3);
        send(0, 8'hE7);
        vld[0] = 1'b0;
        align(4);
        chk("midframe_data_active", {31'd0, qd[0]}, 32'd1);
        chk("midframe_hold_full", {31'd0, rdy[0]}, 32'd0);
        srst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        srst = 1'b0;
        check_idle_16("after_reset");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
